// File: rtl/mem_access_pkg.sv
// ---------------------------------------------------------------------------
// mem_access_pkg : shared MEM-stage types, FSM encoding and timeout limit
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mem_access_pkg;

  localparam int unsigned c_REG_W  = 5;
  localparam int unsigned c_DATA_W = 32;
  localparam int unsigned c_TO_W   = 8;

  localparam logic [c_TO_W-1:0] c_TIMEOUT_LIMIT = 8'd255;

  typedef logic [0:0] state_t;
  localparam state_t c_ST_IDLE = 1'b0;
  localparam state_t c_ST_WAIT = 1'b1;

  typedef struct packed {
    logic                regWrite;
    logic                memToReg;
    logic [c_DATA_W-1:0] aluResult;
    logic [c_DATA_W-1:0] readData;
    logic [c_REG_W-1:0]  writeReg;
  } memwb_t;

endpackage

`default_nettype wire

// File: rtl/mem_access_wb.sv
// ---------------------------------------------------------------------------
// mem_wb : MEM/WB pipeline register; bubble clears the control bits
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_wb
  import mem_access_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   bubble,
  input  logic   load,
  input  memwb_t i_d,
  output memwb_t o_q
);

  memwb_t r_q;

  // Data fields are don't-care under a bubble, so they simply hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (bubble) begin
      r_q.regWrite <= 1'b0;
      r_q.memToReg <= 1'b0;
    end else if (load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/mem_access.sv
// ---------------------------------------------------------------------------
// mem_access : MEM stage data-memory handshake FSM with MEM/WB register.
// Optional access timeout with sticky memErr under MEM_ACCESS_TIMEOUT_EN.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_access
  import mem_access_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        regWrite_MEM,
  input  logic        memToReg_MEM,
  input  logic        memWrite_MEM,
  input  logic        enable_MEM,
  input  logic        regRead_MEM,
  input  logic        Frwrd3_MEM,
  input  logic [31:0] ALUresult_MEM,
  input  logic [4:0]  writeReg_MEM,
  input  logic [31:0] editData_MEM,
  input  logic [31:0] fwdData_WB,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic        stall_MEM,
  output logic        regWrite_WB,
  output logic        memToReg_WB,
  output logic [31:0] ALUresult_WB,
  output logic [31:0] readData_WB,
  output logic [4:0]  writeReg_WB,
  output logic        memErr
);

  state_t r_state;
  state_t w_next_state;

  logic w_accept, w_ack, w_timeout, w_stall, w_bubble, w_load;

  logic        r_dmem_req, r_dmem_we;
  logic [31:0] r_dmem_addr, r_dmem_wdata;

  logic        r_regWrite, r_memToReg, r_memWrite;
  logic [31:0] r_aluResult;
  logic [4:0]  r_writeReg;

  memwb_t w_wb_d, w_wb_q;

  // regRead_MEM is consumed by hazard logic elsewhere, never by this FSM.
  logic w_unused_regread;
  assign w_unused_regread = regRead_MEM;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_ST_IDLE: if (enable_MEM)           w_next_state = c_ST_WAIT;
      c_ST_WAIT: if (dmem_ack || w_timeout) w_next_state = c_ST_IDLE;
      default:                              w_next_state = c_ST_IDLE;
    endcase
  end

  always_comb begin
    w_accept = (r_state == c_ST_IDLE) && enable_MEM;
    w_ack    = (r_state == c_ST_WAIT) && dmem_ack;
    w_stall  = w_accept || ((r_state == c_ST_WAIT) && !dmem_ack && !w_timeout);
    w_bubble = w_stall || w_timeout;
    w_load   = w_ack || ((r_state == c_ST_IDLE) && !enable_MEM);
    w_wb_d   = '0;
    if (w_ack) begin
      w_wb_d.regWrite  = r_regWrite;
      w_wb_d.memToReg  = r_memToReg;
      w_wb_d.aluResult = r_aluResult;
      w_wb_d.writeReg  = r_writeReg;
      w_wb_d.readData  = r_memWrite ? 32'h0 : dmem_rdata;
    end else begin
      w_wb_d.regWrite  = regWrite_MEM;
      w_wb_d.memToReg  = memToReg_MEM;
      w_wb_d.aluResult = ALUresult_MEM;
      w_wb_d.writeReg  = writeReg_MEM;
    end
  end

  // Request signals are held from the accept edge until the ack edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dmem_req   <= 1'b0;
      r_dmem_we    <= 1'b0;
      r_dmem_addr  <= '0;
      r_dmem_wdata <= '0;
    end else if (w_accept) begin
      r_dmem_req   <= 1'b1;
      r_dmem_we    <= memWrite_MEM;
      r_dmem_addr  <= {ALUresult_MEM[31:2], 2'b00};
      r_dmem_wdata <= Frwrd3_MEM ? fwdData_WB : editData_MEM;
    end else if (w_ack || w_timeout) begin
      r_dmem_req   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_regWrite  <= 1'b0;
      r_memToReg  <= 1'b0;
      r_memWrite  <= 1'b0;
      r_aluResult <= '0;
      r_writeReg  <= '0;
    end else if (w_accept) begin
      r_regWrite  <= regWrite_MEM;
      r_memToReg  <= memToReg_MEM;
      r_memWrite  <= memWrite_MEM;
      r_aluResult <= ALUresult_MEM;
      r_writeReg  <= writeReg_MEM;
    end
  end

`ifdef MEM_ACCESS_TIMEOUT_EN
  logic [c_TO_W-1:0] r_to_cnt;
  logic              r_memErr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt <= '0;
      r_memErr <= 1'b0;
    end else begin
      if (w_accept)
        r_to_cnt <= '0;
      else if ((r_state == c_ST_WAIT) && !dmem_ack)
        r_to_cnt <= r_to_cnt + 1'b1;
      if (w_timeout)
        r_memErr <= 1'b1;
    end
  end

  assign w_timeout = (r_state == c_ST_WAIT) && !dmem_ack && (r_to_cnt == c_TIMEOUT_LIMIT);
  assign memErr    = r_memErr;
`else
  assign w_timeout = 1'b0;
  assign memErr    = 1'b0;
`endif

  mem_wb u_mem_wb (
    .clk    (clk),
    .rst_n  (rst_n),
    .bubble (w_bubble),
    .load   (w_load),
    .i_d    (w_wb_d),
    .o_q    (w_wb_q)
  );

  assign stall_MEM    = w_stall;
  assign dmem_req     = r_dmem_req;
  assign dmem_we      = r_dmem_we;
  assign dmem_addr    = r_dmem_addr;
  assign dmem_wdata   = r_dmem_wdata;
  assign regWrite_WB  = w_wb_q.regWrite;
  assign memToReg_WB  = w_wb_q.memToReg;
  assign ALUresult_WB = w_wb_q.aluResult;
  assign readData_WB  = w_wb_q.readData;
  assign writeReg_WB  = w_wb_q.writeReg;

endmodule

`default_nettype wire

// File: tb/tb_mem_access.sv
// ---------------------------------------------------------------------------
// tb_mem_access : scoreboard bench for mem_access (directed vectors)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        regWrite_MEM, memToReg_MEM, memWrite_MEM, enable_MEM, regRead_MEM, Frwrd3_MEM;
  logic [31:0] ALUresult_MEM, editData_MEM, fwdData_WB, dmem_rdata;
  logic [4:0]  writeReg_MEM;
  logic        dmem_ack;
  logic        dmem_req, dmem_we, stall_MEM, regWrite_WB, memToReg_WB, memErr;
  logic [31:0] dmem_addr, dmem_wdata, ALUresult_WB, readData_WB;
  logic [4:0]  writeReg_WB;

  mem_access dut (
    .clk(clk), .rst_n(rst_n),
    .regWrite_MEM(regWrite_MEM), .memToReg_MEM(memToReg_MEM), .memWrite_MEM(memWrite_MEM),
    .enable_MEM(enable_MEM), .regRead_MEM(regRead_MEM), .Frwrd3_MEM(Frwrd3_MEM),
    .ALUresult_MEM(ALUresult_MEM), .writeReg_MEM(writeReg_MEM), .editData_MEM(editData_MEM),
    .fwdData_WB(fwdData_WB), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .stall_MEM(stall_MEM), .regWrite_WB(regWrite_WB), .memToReg_WB(memToReg_WB),
    .ALUresult_WB(ALUresult_WB), .readData_WB(readData_WB), .writeReg_WB(writeReg_WB),
    .memErr(memErr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        rw;
    logic        m2r;
    logic [31:0] alu;
    logic [31:0] rd;
    logic [4:0]  wr;
    int          at;
  } wb_exp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_exp_t;

  typedef struct {
    logic        en, rw, m2r, mw, fw;
    logic [31:0] alu, edit, fwd;
    logic [4:0]  wr;
    logic [31:0] rdata;
    int          delay;
    int          exp_stalls;
    logic [31:0] exp_addr, exp_wdata, exp_rd;
  } vec_t;

  wb_exp_t  wb_q[$];
  req_exp_t req_q[$];

  int          ack_delay = 0;
  logic        resp_en   = 1'b1;
  logic        force_ack = 1'b0;
  logic [31:0] resp_data = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory responder: acks after ack_delay request cycles without ack.
  int resp_cnt = 0;
  initial begin
    dmem_ack   = 1'b0;
    dmem_rdata = 32'hBAD0BAD0;
    forever begin
      @(posedge clk);
      #1;
      dmem_ack   = 1'b0;
      dmem_rdata = 32'hBAD0BAD0;
      if (force_ack) begin
        dmem_ack   = 1'b1;
        dmem_rdata = resp_data;
      end else if (resp_en && dmem_req) begin
        if (resp_cnt == ack_delay) begin
          dmem_ack   = 1'b1;
          dmem_rdata = resp_data;
          resp_cnt   = 0;
        end else begin
          resp_cnt++;
        end
      end else begin
        resp_cnt = 0;
      end
    end
  end

  // Monitor: request rise pops the request queue, WB write pops the WB queue.
  logic     mon_prev_req = 1'b0;
  req_exp_t mon_snap;
  wb_exp_t  mon_wb;
  initial begin
    forever begin
      @(negedge clk);
      if (dmem_req && !mon_prev_req) begin
        if (req_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_req: got addr 0x%08h required no request", dmem_addr);
        end else begin
          mon_snap = req_q.pop_front();
          check("req_we", {31'h0, dmem_we}, {31'h0, mon_snap.we});
          check("req_addr", dmem_addr, mon_snap.addr);
          check("req_wdata", dmem_wdata, mon_snap.wdata);
        end
      end else if (dmem_req) begin
        check("req_stable_addr", dmem_addr, mon_snap.addr);
        check("req_stable_we", {31'h0, dmem_we}, {31'h0, mon_snap.we});
        check("req_stable_wdata", dmem_wdata, mon_snap.wdata);
      end
      mon_prev_req = dmem_req;
      if (regWrite_WB || memToReg_WB) begin
        if (wb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_wb: got wreg %0d alu 0x%08h required no WB write",
                   writeReg_WB, ALUresult_WB);
        end else begin
          mon_wb = wb_q.pop_front();
          check("wb_cycle", cyc, mon_wb.at);
          check("wb_regWrite", {31'h0, regWrite_WB}, {31'h0, mon_wb.rw});
          check("wb_memToReg", {31'h0, memToReg_WB}, {31'h0, mon_wb.m2r});
          check("wb_alu", ALUresult_WB, mon_wb.alu);
          check("wb_wreg", {27'h0, writeReg_WB}, {27'h0, mon_wb.wr});
          check("wb_rdata", readData_WB, mon_wb.rd);
        end
      end
    end
  end

  task automatic drive_nop();
    enable_MEM = 0; regWrite_MEM = 0; memToReg_MEM = 0; memWrite_MEM = 0;
    regRead_MEM = 0; Frwrd3_MEM = 0; ALUresult_MEM = 0; editData_MEM = 0;
    fwdData_WB = 0; writeReg_MEM = 0;
  endtask

  task automatic drive_vec(input vec_t v);
    enable_MEM = v.en; regWrite_MEM = v.rw; memToReg_MEM = v.m2r; memWrite_MEM = v.mw;
    regRead_MEM = v.m2r; Frwrd3_MEM = v.fw; ALUresult_MEM = v.alu; editData_MEM = v.edit;
    fwdData_WB = v.fwd; writeReg_MEM = v.wr;
  endtask

  // Presents one instruction in EX/MEM and holds it while stall_MEM is high.
  task automatic issue(input string name, input vec_t v);
    int  stalls;
    bool_done: begin end
    stalls    = 0;
    ack_delay = v.delay;
    resp_data = v.rdata;
    drive_vec(v);
    if (v.en) req_q.push_back('{v.mw, v.exp_addr, v.exp_wdata});
    if (v.rw || v.m2r) wb_q.push_back('{v.rw, v.m2r, v.alu, v.exp_rd, v.wr, cyc + v.exp_stalls + 1});
    for (int n = 0; n < 300; n++) begin
      logic s;
      @(negedge clk);
      s = stall_MEM;
      @(posedge clk);
      #1;
      if (!s) break;
      stalls++;
    end
    check({name, "_stall_cycles"}, stalls, v.exp_stalls);
    drive_nop();
  endtask

  vec_t v_alu, v_ld, v_st_fwd, v_st_nofwd, v_ld1, v_ld2, v_alu2, v_hang;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    v_alu      = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1234, 32'h0, 32'h0, 5'd5, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0};
    v_ld       = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h103, 32'h0, 32'h0, 5'd7, 32'hDEADBEEF, 3, 4, 32'h100, 32'h0, 32'hDEADBEEF};
    v_st_fwd   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h208, 32'h0, 32'hA5A5A5A5, 5'd0, 32'h0, 1, 2, 32'h208, 32'hA5A5A5A5, 32'h0};
    v_st_nofwd = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h30E, 32'h11223344, 32'hFFFFFFFF, 5'd0, 32'h0, 0, 1, 32'h30C, 32'h11223344, 32'h0};
    v_ld1      = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h400, 32'h0, 32'h0, 5'd1, 32'h00001111, 0, 1, 32'h400, 32'h0, 32'h00001111};
    v_ld2      = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h404, 32'h0, 32'h0, 5'd2, 32'h22220000, 0, 1, 32'h404, 32'h0, 32'h22220000};
    v_alu2     = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h55, 32'h0, 32'h0, 5'd3, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0};
    v_hang     = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h500, 32'h0, 32'h0, 5'd9, 32'h0, 0, 0, 32'h500, 32'h0, 32'h0};

    drive_nop();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_dmem_req", {31'h0, dmem_req}, 32'h0);
    check("rst_dmem_we", {31'h0, dmem_we}, 32'h0);
    check("rst_dmem_addr", dmem_addr, 32'h0);
    check("rst_dmem_wdata", dmem_wdata, 32'h0);
    check("rst_regWrite_WB", {31'h0, regWrite_WB}, 32'h0);
    check("rst_memToReg_WB", {31'h0, memToReg_WB}, 32'h0);
    check("rst_ALUresult_WB", ALUresult_WB, 32'h0);
    check("rst_readData_WB", readData_WB, 32'h0);
    check("rst_writeReg_WB", {27'h0, writeReg_WB}, 32'h0);
    check("rst_memErr", {31'h0, memErr}, 32'h0);
    check("rst_stall", {31'h0, stall_MEM}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    issue("alu", v_alu);
    issue("load", v_ld);
    issue("store_fwd", v_st_fwd);
    @(negedge clk);
    check("store_no_regwrite", {31'h0, regWrite_WB}, 32'h0);
    @(posedge clk);
    #1;
    issue("store_nofwd", v_st_nofwd);
    issue("b2b_ld1", v_ld1);
    issue("b2b_ld2", v_ld2);
    issue("b2b_alu", v_alu2);
    repeat (3) @(posedge clk);
    #1;

    // Reset in the middle of an outstanding access, then a stray ack.
    resp_en = 1'b0;
    drive_vec(v_hang);
    req_q.push_back('{1'b0, 32'h500, 32'h0});
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("midwait_req_high", {31'h0, dmem_req}, 32'h1);
    check("midwait_stall_high", {31'h0, stall_MEM}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_req_low", {31'h0, dmem_req}, 32'h0);
    drive_nop();
    @(negedge clk);
    rst_n = 1'b1;
    resp_data = 32'hFEEDFACE;
    force_ack = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    force_ack = 1'b0;
    @(negedge clk);
    check("late_ack_regWrite", {31'h0, regWrite_WB}, 32'h0);
    check("late_ack_memToReg", {31'h0, memToReg_WB}, 32'h0);
    check("late_ack_req", {31'h0, dmem_req}, 32'h0);
    check("late_ack_stall", {31'h0, stall_MEM}, 32'h0);
    @(posedge clk);
    #1;

`ifdef MEM_ACCESS_TIMEOUT_EN
    begin
      int to_stalls;
      to_stalls = 0;
      drive_vec(v_hang);
      req_q.push_back('{1'b0, 32'h500, 32'h0});
      for (int n = 0; n < 400; n++) begin
        logic s;
        @(negedge clk);
        s = stall_MEM;
        if (!s) break;
        @(posedge clk);
        #1;
        to_stalls++;
      end
      check("timeout_stall_cycles", to_stalls, 256);
      check("timeout_stall_low", {31'h0, stall_MEM}, 32'h0);
      check("timeout_req_before", {31'h0, dmem_req}, 32'h1);
      check("timeout_err_before", {31'h0, memErr}, 32'h0);
      @(posedge clk);
      #1;
      drive_nop();
      @(negedge clk);
      check("timeout_req_low", {31'h0, dmem_req}, 32'h0);
      check("timeout_memErr", {31'h0, memErr}, 32'h1);
      check("timeout_regWrite", {31'h0, regWrite_WB}, 32'h0);
      check("timeout_stall_after", {31'h0, stall_MEM}, 32'h0);
      repeat (2) @(negedge clk);
      check("timeout_memErr_sticky", {31'h0, memErr}, 32'h1);
    end
`else
    check("memErr_tied_low", {31'h0, memErr}, 32'h0);
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("wb_queue_drained", wb_q.size(), 32'h0);
    check("req_queue_drained", req_q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Module SHALL have one clock and an asynchronous active-low reset; ports `clk` and `rst_n`.
REQ-002 Ports (name  direction  width  meaning):
- clk  in  1  rising-edge clock
- rst_n  in  1  async active-low reset
- regWrite_MEM, memToReg_MEM, memWrite_MEM, enable_MEM, regRead_MEM, Frwrd3_MEM  in  1 each  EX/MEM control fields
- ALUresult_MEM  in  32  byte address or ALU result
- writeReg_MEM  in  5  destination register
- editData_MEM  in  32  store data
- fwdData_WB  in  32  write-back value for store-data forwarding
- dmem_rdata  in  32  memory read data
- dmem_ack  in  1  memory completion
- dmem_req  out  1  memory request
- dmem_we  out  1  memory write
- dmem_addr  out  32  word-aligned address
- dmem_wdata  out  32  store data
- stall_MEM  out  1  hold EX/MEM and all upstream stages
- regWrite_WB, memToReg_WB  out  1 each  MEM/WB control
- ALUresult_WB, readData_WB  out  32 each  MEM/WB data
- writeReg_WB  out  5  MEM/WB destination
- memErr  out  1  sticky timeout flag

Function
REQ-003 FSM SHALL have two states: IDLE and WAIT.
REQ-004 In IDLE with enable_MEM=1, the access SHALL be accepted at the clock edge:
- dmem_addr <= {ALUresult_MEM[31:2],2'b00}
- dmem_we <= memWrite_MEM
- dmem_wdata <= Frwrd3_MEM ? fwdData_WB : editData_MEM
- dmem_req <= 1
- control fields captured
- next state WAIT
REQ-005 dmem_req, dmem_we, dmem_addr and dmem_wdata SHALL stay stable from the accepting edge until the edge on which dmem_ack=1 is sampled in WAIT.
REQ-006 In WAIT with dmem_ack=1, at that edge:
- dmem_req <= 0
- readData_WB <= dmem_rdata for a load, 0 for a store
- MEM/WB outputs <= captured fields
- next state IDLE
REQ-007 dmem_ack SHALL be ignored in IDLE.
REQ-008 stall_MEM SHALL be combinational and equal (IDLE && enable_MEM) || (WAIT && !dmem_ack).
REQ-009 On every edge where stall_MEM=1, MEM/WB SHALL load a bubble: regWrite_WB=0, memToReg_WB=0; other WB fields are don't-care.
REQ-010 In IDLE with enable_MEM=0, MEM/WB SHALL load the EX/MEM fields directly, with one-cycle latency and readData_WB=0.
REQ-011 Minimum memory-op latency SHALL be two cycles (accept edge, then ack edge); there is no upper bound unless REQ-016 applies.
REQ-012 A new access SHALL be acceptable in the IDLE cycle immediately after an ack, giving back-to-back operation.
REQ-013 regRead_MEM SHALL be carried for hazard logic only and SHALL NOT affect the FSM.

Reset
REQ-014 rst_n=0 SHALL asynchronously force:
- state IDLE
- dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0
- all *_WB outputs 0
- memErr=0
- timeout counter 0
REQ-015 Reset asserted during WAIT SHALL abandon the access with no WB write; a late dmem_ack after reset SHALL be ignored.

Configuration
REQ-016 With MEM_ACCESS_TIMEOUT_EN defined:
- an 8-bit counter SHALL clear on accept and increment each WAIT cycle without ack
- on the WAIT edge where the counter equals 255 with no ack: dmem_req <= 0, state <= IDLE, MEM/WB loads a bubble, memErr <= 1 (sticky until reset)
- stall_MEM SHALL deassert in that cycle
REQ-017 Without MEM_ACCESS_TIMEOUT_EN, no counter SHALL exist, WAIT SHALL persist until ack, and memErr SHALL be tied to 0.

Structure
REQ-018 A shared pipeline package SHALL hold the FSM state encoding, the MEM/WB bundle field widths (5-bit register index, 32-bit data), and the timeout limit constant 255.
REQ-019 The MEM/WB output register SHALL be a sub-module `mem_wb` with `bubble` and `load` controls; the FSM and handshake logic SHALL stay in `mem_access`.

Verification
REQ-020 Bench SHALL cover these directed scenarios:
- ALU op: enable_MEM=0, ALUresult_MEM=0x1234, writeReg_MEM=5, regWrite_MEM=1 -> next edge ALUresult_WB=0x1234, writeReg_WB=5, regWrite_WB=1; stall_MEM never 1.
- Load with ack after 3 WAIT cycles: ALUresult_MEM=0x103, dmem_rdata=0xDEADBEEF -> dmem_addr=0x100; stall_MEM high 4 cycles; bubbles meanwhile; then readData_WB=0xDEADBEEF, memToReg_WB=1.
- Store with Frwrd3_MEM=1, fwdData_WB=0xA5A5A5A5, editData_MEM=0x0 -> dmem_we=1, dmem_wdata=0xA5A5A5A5; regWrite_WB=0.
- Back-to-back loads with immediate ack -> each completes two cycles after its accept; no lost or duplicated WB writes.
- Reset asserted mid-WAIT -> dmem_req falls without waiting for a clock edge; a later ack produces no WB write.
- With MEM_ACCESS_TIMEOUT_EN and no ack -> 255 WAIT cycles, then dmem_req=0, memErr=1, stall_MEM=0, regWrite_WB=0.
